// File: rtl/sb_arbiter.sv
// sb_arbiter: round-robin arbiter sharing the iCE40 UltraPlus SB hard-IP bus
// between NUM_REQ_P requesters. One SB transaction per grant; read data and a
// one-hot ready pulse are returned in the RESP cycle.
// Optional build macro: SB_ARB_TIMEOUT_EN adds an ack timeout of TIMEOUT_P cycles.
module sb_arbiter #(
  parameter int NUM_REQ_P = 2,
  parameter int TIMEOUT_P = 255
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_REQ_P-1:0]   req_valid_i,
  input  logic [NUM_REQ_P-1:0]   req_wr_i,
  input  logic [NUM_REQ_P*4-1:0] req_adr_i,
  input  logic [NUM_REQ_P*8-1:0] req_dat_i,
  output logic [NUM_REQ_P-1:0]   req_ready_o,
  output logic [7:0]             rsp_dat_o,
  output logic                   rsp_err_o,
  output logic [NUM_REQ_P-1:0]   grant_o,
  output logic                   busy_o,
  output logic                   sbwr_o,
  output logic                   sbstb_o,
  output logic [3:0]             sbadri_o,
  output logic [7:0]             sbdati_o,
  input  logic [7:0]             sbdato_i,
  input  logic                   sback_i
);

  localparam int IDX_W = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] sel;
  logic             any_req;
  logic             issue_end;

  // Per-requester views of the packed address/data buses
  logic [3:0] adr_arr [NUM_REQ_P];
  logic [7:0] dat_arr [NUM_REQ_P];

  generate
    for (genvar gi = 0; gi < NUM_REQ_P; gi++) begin : g_split
      assign adr_arr[gi] = req_adr_i[gi*4 +: 4];
      assign dat_arr[gi] = req_dat_i[gi*8 +: 8];
    end
  endgenerate

  function automatic logic [NUM_REQ_P-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [NUM_REQ_P-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

`ifdef SB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_P + 1) > 8) ? $clog2(TIMEOUT_P + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  // Counter would reach TIMEOUT_P on this edge: strobe has been up TIMEOUT_P cycles
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_P - 1));
  assign issue_end = sback_i | tmo_hit;
`else
  assign issue_end = sback_i;
  assign rsp_err_o = 1'b0;
`endif

  // Round-robin search starting just above the last owner; walking the
  // offsets downward lets the smallest offset overwrite and win.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] idx;
    sel     = '0;
    any_req = 1'b0;
    cand    = 0;
    idx     = '0;
    for (int i = NUM_REQ_P; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ_P) cand = cand - NUM_REQ_P;
      idx = IDX_W'(cand);
      if (req_valid_i[idx]) begin
        sel     = idx;
        any_req = 1'b1;
      end
    end
  end

  // Arbiter FSM; every output is a register so nothing from req_* reaches the SB pins combinationally
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      win         <= '0;
      last_grant  <= IDX_W'(NUM_REQ_P - 1);
      req_ready_o <= '0;
      rsp_dat_o   <= 8'h00;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      sbwr_o      <= 1'b0;
      sbstb_o     <= 1'b0;
      sbadri_o    <= 4'h0;
      sbdati_o    <= 8'h00;
`ifdef SB_ARB_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win      <= sel;
            grant_o  <= onehot(sel);
            busy_o   <= 1'b1;
            sbstb_o  <= 1'b1;
            sbwr_o   <= req_wr_i[sel];
            sbadri_o <= adr_arr[sel];
            sbdati_o <= dat_arr[sel];
`ifdef SB_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_end) begin
            last_grant  <= win;
            req_ready_o <= onehot(win);
            sbstb_o     <= 1'b0;
            sbwr_o      <= 1'b0;
            sbadri_o    <= 4'h0;
            sbdati_o    <= 8'h00;
            state       <= RESP;
            // Ack beats a simultaneous timeout
            if (sback_i) begin
              rsp_dat_o <= sbwr_o ? 8'h00 : sbdato_i;
`ifdef SB_ARB_TIMEOUT_EN
              rsp_err_o <= 1'b0;
`endif
            end else begin
              rsp_dat_o <= 8'h00;
`ifdef SB_ARB_TIMEOUT_EN
              rsp_err_o <= 1'b1;
`endif
            end
          end
`ifdef SB_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          req_ready_o <= '0;
          grant_o     <= '0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sb_arbiter.md
# sb_arbiter

Round-robin arbiter that shares the single iCE40 UltraPlus hard-IP system bus (SB) between several requesters, e.g. the camera I2C configuration sequencer and a status/readback poller. Each requester posts one SB transaction (read or write, 4-bit register address, 8-bit data). The arbiter grants the bus to one requester, drives the SB strobe until `sback_i`, and returns read data plus a one-cycle completion pulse. It sits between the requesters and the SB hard-IP primitive.

## Interface
- `NUM_REQ_P`, default 2: number of requesters, at least 2.
- `TIMEOUT_P`, default 255: SB ack timeout in cycles; used only with `SB_ARB_TIMEOUT_EN`.
- `clk_i`  in  1: system clock.
- `rstn_i`  in  1: reset, asynchronous and active-low.
- `req_valid_i`  in  NUM_REQ_P: per-requester transaction request.
- `req_wr_i`  in  NUM_REQ_P: 1 = write, 0 = read.
- `req_adr_i`  in  NUM_REQ_P*4: SB register address; requester k uses bits [4k+3:4k].
- `req_dat_i`  in  NUM_REQ_P*8: write data; requester k uses bits [8k+7:8k].
- `req_ready_o`  out  NUM_REQ_P: one-hot, one-cycle completion pulse.
- `rsp_dat_o`  out  8: read data. Valid while `req_ready_o` is nonzero.
- `rsp_err_o`  out  1: timeout flag. Valid while `req_ready_o` is nonzero.
- `grant_o`  out  NUM_REQ_P: one-hot current owner. Zero in IDLE.
- `busy_o`  out  1: high in ISSUE and RESP.
- `sbwr_o`, `sbstb_o`  out  1 each: SB write enable and strobe.
- `sbadri_o`  out  4, `sbdati_o`  out  8: SB address and write data.
- `sbdato_i`  in  8: SB read data.
- `sback_i`  in  1: SB acknowledge.

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid_i` bit is high, select a winner by searching from `last_grant+1` upward, wrapping modulo NUM_REQ_P.
  - In the same edge, latch the winner's index, `wr`, `adr` and `dat`, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - `sbstb_o` = 1.
  - `sbwr_o`, `sbadri_o` and `sbdati_o` come from the latched values, so they are stable for the whole strobe.
  - `grant_o` is one-hot on the winner.
  - When `sback_i` is sampled high: capture `sbdato_i` into `rsp_dat_o` (reads only; writes load 0x00), clear the error flag, set `last_grant` = winner, and go to RESP.
- **RESP**
  - Exactly one cycle.
  - `req_ready_o[winner]` = 1; all SB outputs are 0.
  - Next state is IDLE.
  - `grant_o` remains on the winner during RESP.
- **Requester rules**
  - Request fields need to be valid only in the cycle the request is granted.
  - The requester must deassert `req_valid_i` in the cycle it sees its ready pulse. If it is still high in the following IDLE cycle, that is a new request.
  - Dropping `req_valid_i` during ISSUE does not abort the transaction: the SB cycle completes and the ready pulse still occurs.
- **Outside ISSUE**
  - `sback_i` is ignored in IDLE and RESP.
  - `sbdato_i` is sampled only on the ack edge.
- **Reset** (asynchronous, any state)
  - State goes to IDLE.
  - All outputs go to 0: `sbstb_o`, `sbwr_o`, `sbadri_o`, `sbdati_o`, `grant_o`, `req_ready_o`, `rsp_dat_o`, `rsp_err_o`, `busy_o`.
  - `last_grant` = NUM_REQ_P-1, so requester 0 wins first after reset.
  - A transaction in progress is abandoned with no ready pulse.

## Timing
- Request sampled in IDLE at edge N:
  - ISSUE, strobe and grant visible from cycle N+1.
  - `sback_i` sampled high at edge M: `req_ready_o` high during cycle M+1 (RESP); IDLE again at M+2.
- Minimum occupancy is 3 cycles per transaction (IDLE → ISSUE with immediate ack → RESP).
- Back-to-back: a different pending requester is granted in the IDLE cycle after RESP. No request starves; worst-case wait is NUM_REQ_P-1 transactions.
- All outputs are decoded from registered state and latched fields only; there is no combinational path from the `req_*` inputs to the SB outputs.

## Configuration
- `SB_ARB_TIMEOUT_EN` defined:
  - An 8-bit-minimum cycle counter clears on entry to ISSUE and increments each ISSUE cycle.
  - On reaching TIMEOUT_P with no ack: drop the strobe, go to RESP with `rsp_err_o` = 1 and `rsp_dat_o` = 0x00, and advance `last_grant` as normal.
  - If `sback_i` arrives in the same cycle the counter reaches TIMEOUT_P, the ack wins and `rsp_err_o` = 0.
- `SB_ARB_TIMEOUT_EN` undefined:
  - ISSUE waits indefinitely for `sback_i`.
  - `rsp_err_o` is tied 0 and no counter is instantiated.

## Test plan
- Write: req0 write adr 0x1, dat 0x80; ack on the 3rd ISSUE cycle → `sbstb_o` high 3 cycles with `sbwr_o` = 1, `sbadri_o` = 0x1, `sbdati_o` = 0x80; one `req_ready_o` = 01 pulse; `rsp_err_o` = 0.
- Read: req1 read adr 0x6, `sbdato_i` = 0xA5 at ack → `req_ready_o` = 10 with `rsp_dat_o` = 0xA5 in the same cycle.
- Fairness: both requesters continuously valid, immediate acks, 6 transactions → grant order 0,1,0,1,0,1; each transaction 3 cycles.
- Timeout: build with `SB_ARB_TIMEOUT_EN`, TIMEOUT_P = 8, no ack → strobe drops after 8 ISSUE cycles; ready pulse with `rsp_err_o` = 1 and `rsp_dat_o` = 0x00; the next requester is then serviced normally.
- Ack/timeout collision: ack on the terminal-count cycle → `rsp_err_o` = 0 and read data captured.
- Reset mid-ISSUE: assert `rstn_i` low asynchronously → all outputs 0 immediately, no ready pulse; after release with both requesting, requester 0 is granted first.
